// File: rtl/mem_wait_gen.sv
// Per-port memory wait-state generator: stretches triggered accesses by WAIT_CYCLES stall
// cycles followed by a one-cycle grant, and keeps saturating per-port stall counters.
module mem_wait_gen #(
    parameter int unsigned NPORTS      = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] MATCH_MASK  = 32'h0000_000C,
    parameter logic [31:0] MATCH_VALUE = 32'h0000_000C,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      req,
    input  logic [NPORTS*AW-1:0]   addr,
    input  logic [2*NPORTS-1:0]    mode,
    input  logic                   clr_cnt,
    output logic [NPORTS-1:0]      wait_c,
    output logic [16*NPORTS-1:0]   stall_cnt
);

    localparam int unsigned CW = 4;
    localparam int unsigned SW = 16;
    localparam logic [CW-1:0] LOAD_VAL  = CW'(WAIT_CYCLES - 1);
    localparam logic [AW-1:0] MASK      = AW'(MATCH_MASK);
    localparam logic [AW-1:0] VALUE     = AW'(MATCH_VALUE);
    localparam logic [SW-1:0] SAT_VAL   = '1;
    localparam bit            HAS_STALL = (WAIT_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    state_e        state_q     [NPORTS];
    state_e        state_d     [NPORTS];
    logic [CW-1:0] cnt_q       [NPORTS];
    logic [CW-1:0] cnt_d       [NPORTS];
    logic [SW-1:0] stall_cnt_q [NPORTS];
    logic [SW-1:0] stall_cnt_d [NPORTS];
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_d;
    logic [NPORTS-1:0] trig_c;
    logic [NPORTS-1:0] wait_raw_c;

    // Per-port trigger decode from the selected mode
    always_comb begin
        trig_c = '0;
        for (int i = 0; i < NPORTS; i++) begin
            case (mode[2*i +: 2])
                2'b01:   trig_c[i] = req[i] & ((addr[i*AW +: AW] & MASK) == VALUE);
                2'b10:   trig_c[i] = req[i];
                2'b11:   trig_c[i] = req[i] & lfsr_q[i];
                default: trig_c[i] = 1'b0;
            endcase
        end
    end

    // Next-state and Mealy wait; triggers are only looked at in IDLE
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            wait_raw_c[i] = 1'b0;
            case (state_q[i])
                ST_IDLE: begin
                    if (trig_c[i]) begin
                        wait_raw_c[i] = 1'b1;
                        cnt_d[i]      = LOAD_VAL;
                        state_d[i]    = HAS_STALL ? ST_STALL : ST_GRANT;
                    end
                end
                ST_STALL: begin
                    wait_raw_c[i] = 1'b1;
                    cnt_d[i]      = cnt_q[i] - CW'(1);
                    if (cnt_q[i] == CW'(1)) begin
                        state_d[i] = ST_GRANT;
                    end
                end
                ST_GRANT: state_d[i] = ST_IDLE;
                default:  state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Reset is asynchronous, so the combinational wait must be masked as well
    assign wait_c = wait_raw_c & {NPORTS{reset}};

    // Saturating stall counters; clear has priority over increment
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            stall_cnt_d[i] = stall_cnt_q[i];
            if (clr_cnt) begin
                stall_cnt_d[i] = '0;
            end else if (wait_c[i] && (stall_cnt_q[i] != SAT_VAL)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + SW'(1);
            end
        end
    end

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, right-shifting
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPORTS; i++) begin
                state_q[i]     <= ST_IDLE;
                cnt_q[i]       <= '0;
                stall_cnt_q[i] <= '0;
            end
            lfsr_q <= LFSR_SEED;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                state_q[i]     <= state_d[i];
                cnt_q[i]       <= cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
            lfsr_q <= lfsr_d;
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_cnt_out
        assign stall_cnt[SW*g +: SW] = stall_cnt_q[g];
    end

endmodule

// File: tb/tb_mem_wait_gen.sv
// Randomised and directed checks of mem_wait_gen against a sequence-length reference model,
// using three instances: defaults (2 ports, 2 waits), 4 ports/AW16/15 waits, 1 port/5 waits.
module tb_mem_wait_gen;

    localparam int unsigned NI   = 3;
    localparam int unsigned NP_A = 2;
    localparam int unsigned NP_B = 4;
    localparam int unsigned NP_C = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clr_cnt;
    logic [15:0] req_v;
    logic [31:0] addr_v [16];
    logic [1:0]  mode_v [16];

    logic [NP_A-1:0]    req_w2,  wait_w2;
    logic [NP_A*32-1:0] addr_w2;
    logic [2*NP_A-1:0]  mode_w2;
    logic [16*NP_A-1:0] stall_w2;
    logic [NP_B-1:0]    req_w15, wait_w15;
    logic [NP_B*16-1:0] addr_w15;
    logic [2*NP_B-1:0]  mode_w15;
    logic [16*NP_B-1:0] stall_w15;
    logic [NP_C-1:0]    req_w5,  wait_w5;
    logic [NP_C*32-1:0] addr_w5;
    logic [2*NP_C-1:0]  mode_w5;
    logic [16*NP_C-1:0] stall_w5;

    assign req_w2  = req_v[NP_A-1:0];
    assign req_w15 = req_v[NP_B-1:0];
    assign req_w5  = req_v[NP_C-1:0];

    always_comb begin
        for (int p = 0; p < NP_A; p++) begin
            addr_w2[32*p +: 32] = addr_v[p];
            mode_w2[2*p +: 2]   = mode_v[p];
        end
        for (int p = 0; p < NP_B; p++) begin
            addr_w15[16*p +: 16] = addr_v[p][15:0];
            mode_w15[2*p +: 2]   = mode_v[p];
        end
        for (int p = 0; p < NP_C; p++) begin
            addr_w5[32*p +: 32] = addr_v[p];
            mode_w5[2*p +: 2]   = mode_v[p];
        end
    end

    mem_wait_gen u_w2 (
        .clk(clk), .reset(reset), .req(req_w2), .addr(addr_w2), .mode(mode_w2),
        .clr_cnt(clr_cnt), .wait_c(wait_w2), .stall_cnt(stall_w2)
    );

    mem_wait_gen #(.NPORTS(NP_B), .AW(16), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .reset(reset), .req(req_w15), .addr(addr_w15), .mode(mode_w15),
        .clr_cnt(clr_cnt), .wait_c(wait_w15), .stall_cnt(stall_w15)
    );

    mem_wait_gen #(.NPORTS(NP_C), .WAIT_CYCLES(5)) u_w5 (
        .clk(clk), .reset(reset), .req(req_w5), .addr(addr_w5), .mode(mode_w5),
        .clr_cnt(clr_cnt), .wait_c(wait_w5), .stall_cnt(stall_w5)
    );

    int          np_t [NI] = '{2, 4, 1};
    int          wc_t [NI] = '{2, 15, 5};
    // left_m: cycles still owed by the current access (waits plus the final grant)
    int          left_m [NI][16];
    logic [15:0] sc_m   [NI][16];
    logic [15:0] lfsr_m;
    logic        samp   [NI][16];
    string       tag_w  [NI][16];
    string       tag_s  [NI][16];
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic dut_wait(int k, int p);
        case (k)
            0:       return wait_w2[p];
            1:       return wait_w15[p];
            default: return wait_w5[p];
        endcase
    endfunction

    function automatic logic [15:0] dut_stall(int k, int p);
        case (k)
            0:       return stall_w2[16*p +: 16];
            1:       return stall_w15[16*p +: 16];
            default: return stall_w5[16*p +: 16];
        endcase
    endfunction

    function automatic logic trig_m(int p);
        case (mode_v[p])
            2'b01:   return req_v[p] && ((addr_v[p] & 32'hC) == 32'hC);
            2'b10:   return req_v[p];
            2'b11:   return req_v[p] && lfsr_m[p];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_wait(int k, int p);
        if (!reset) return 1'b0;
        if (left_m[k][p] > 1) return 1'b1;
        if (left_m[k][p] == 1) return 1'b0;
        return trig_m(p);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++)
            for (int p = 0; p < 16; p++) begin
                left_m[k][p] = 0;
                sc_m[k][p]   = 16'h0;
            end
        lfsr_m = 16'hACE1;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge
    task automatic cycle();
        logic        w;
        logic [15:0] t;
        @(negedge clk);
        if (!reset) model_reset();
        for (int k = 0; k < NI; k++)
            for (int p = 0; p < np_t[k]; p++) begin
                samp[k][p] = dut_wait(k, p);
                check_eq(tag_w[k][p], 32'(dut_wait(k, p)), 32'(exp_wait(k, p)));
                check_eq(tag_s[k][p], 32'(dut_stall(k, p)), 32'(sc_m[k][p]));
            end
        if (reset) begin
            for (int k = 0; k < NI; k++)
                for (int p = 0; p < np_t[k]; p++) begin
                    w = exp_wait(k, p);
                    if (clr_cnt) sc_m[k][p] = 16'h0;
                    else if (w && sc_m[k][p] != 16'hFFFF) sc_m[k][p] = sc_m[k][p] + 16'h1;
                    if (left_m[k][p] > 0) left_m[k][p] = left_m[k][p] - 1;
                    else if (trig_m(p)) left_m[k][p] = wc_t[k];
                end
            t = lfsr_m ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5);
            lfsr_m = {t[0], lfsr_m[15:1]};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic r, input logic [1:0] m);
        for (int p = 0; p < 16; p++) begin
            req_v[p]  = r;
            mode_v[p] = m;
        end
    endtask

    task automatic drain(input int n);
        set_all(1'b0, 2'b00);
        clr_cnt = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < NI; k++)
            for (int p = 0; p < 16; p++) begin
                tag_w[k][p] = $sformatf("wait_i%0d_p%0d", k, p);
                tag_s[k][p] = $sformatf("stall_cnt_i%0d_p%0d", k, p);
                addr_v[p]   = 32'h0;
            end
        model_reset();
        reset   = 1'b0;
        clr_cnt = 1'b0;
        set_all(1'b1, 2'b10);
        #1;
        check_eq("rst_wait_w2", 32'(wait_w2), 32'h0);
        check_eq("rst_wait_w15", 32'(wait_w15), 32'h0);
        check_eq("rst_stall_w2", stall_w2, 32'h0);
        repeat (3) cycle();

        // Address-match hit held: 1,1,0 repeating; then a miss never stalls
        reset = 1'b1;
        drain(2);
        req_v[0] = 1'b1; mode_v[0] = 2'b01; addr_v[0] = 32'h0000_100C;
        for (int i = 0; i < 9; i++) begin
            cycle();
            check_eq("hit_pattern_w2", 32'(samp[0][0]), 32'((i % 3) != 2));
        end
        addr_v[0] = 32'h0000_1008;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_eq("miss_w2", 32'(samp[0][0]), 32'h0);
        end

        // Port 0 every-access, port 1 off
        drain(16);
        req_v[0] = 1'b1; req_v[1] = 1'b1; mode_v[0] = 2'b10; mode_v[1] = 2'b00;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_eq("every_w2_p0", 32'(samp[0][0]), 32'((i % 3) != 2));
            check_eq("off_w2_p1", 32'(samp[0][1]), 32'h0);
        end
        check_eq("off_stall_w2_p1", 32'(stall_w2[31:16]), 32'h0);

        // Single-cycle pulse: 5 waits on the 5-wait instance, 15 on the 15-wait one
        drain(20);
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        req_v[0] = 1'b1; mode_v[0] = 2'b10;
        for (int i = 0; i < 7; i++) begin
            cycle();
            req_v[0] = 1'b0;
            check_eq("pulse_w5", 32'(samp[2][0]), 32'(i < 5));
        end
        check_eq("pulse_stall_w5", 32'(stall_w5[15:0]), 32'd5);
        drain(12);
        check_eq("pulse_stall_w15", 32'(stall_w15[15:0]), 32'd15);
        check_eq("pulse_stall_w2", 32'(stall_w2[15:0]), 32'd2);

        // Reset in the second stall cycle aborts the sequence
        drain(20);
        req_v[0] = 1'b1; mode_v[0] = 2'b10;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check_eq("abort_wait_w5", 32'(wait_w5), 32'h0);
        check_eq("abort_stall_w5", 32'(stall_w5), 32'h0);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        check_eq("fresh_wait_w5", 32'(samp[2][0]), 32'h1);
        check_eq("fresh_wait_w2", 32'(samp[0][0]), 32'h1);

        // Pseudo-random mode against the reference LFSR
        drain(20);
        set_all(1'b1, 2'b11);
        repeat (1000) cycle();

        // Random traffic with occasional clears and resets
        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < 16; p++) begin
                req_v[p]  = 1'($urandom_range(1));
                mode_v[p] = 2'($urandom_range(3));
                addr_v[p] = $urandom;
            end
            clr_cnt = ($urandom_range(19) == 0);
            reset   = ($urandom_range(149) != 0);
            cycle();
        end

        // Counter saturation and clear-over-increment
        reset = 1'b1;
        drain(20);
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        set_all(1'b1, 2'b10);
        guard = 0;
        while (sc_m[1][0] != 16'hFFFE && guard < 80000) begin
            cycle();
            guard++;
        end
        check_eq("preload_w15", 32'(stall_w15[15:0]), 32'hFFFE);
        repeat (3) cycle();
        check_eq("sat_w15", 32'(stall_w15[15:0]), 32'hFFFF);
        repeat (20) cycle();
        check_eq("sat_hold_w15", 32'(stall_w15[15:0]), 32'hFFFF);
        guard = 0;
        while (left_m[1][0] <= 1 && guard < 20) begin
            cycle();
            guard++;
        end
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        check_eq("clr_wins_w15", 32'(stall_w15[15:0]), 32'h0);
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wait_gen.md
MEM_WAIT_GEN -- requirements
Module: mem_wait_gen

Interface
- REQ-001: Parameter NPORTS, default 2, number of independent memory ports (legal 1..16).
- REQ-002: Parameter AW, default 32, address width per port.
- REQ-003: Parameter WAIT_CYCLES, default 2, wait cycles inserted per triggered access (legal 1..15).
- REQ-004: Parameters MATCH_MASK and MATCH_VALUE, defaults 32'h0000_000C and 32'h0000_000C, address-match trigger: (addr & MATCH_MASK) == MATCH_VALUE.
- REQ-005: Parameter LFSR_SEED, default 16'hACE1, LFSR reset value (nonzero).
- REQ-006: clk  input  1  single clock; all state on rising edge.
- REQ-007: reset  input  1  asynchronous, active-low reset.
- REQ-008: req  input  NPORTS  per-port access strobe.
- REQ-009: addr  input  NPORTS*AW  per-port address; port i at [i*AW +: AW].
- REQ-010: mode  input  2*NPORTS  per-port trigger mode at [2i +: 2]: 00 off, 01 address-match, 10 every access, 11 pseudo-random.
- REQ-011: clr_cnt  input  1  synchronous clear of all stall counters.
- REQ-012: wait  output  NPORTS  per-port stall indication to the core.
- REQ-013: stall_cnt  output  16*NPORTS  per-port saturating stall-cycle count at [16i +: 16].

Function
- REQ-014: Each port has an independent FSM with states IDLE, STALL, GRANT plus a 4-bit down-counter.
- REQ-015: trigger[i] = req[i] AND (mode 01: address match; mode 10: 1; mode 11: lfsr[i]; mode 00: 0).
- REQ-016: IDLE: wait[i] = trigger[i] combinationally (Mealy, same cycle); on trigger, counter loads WAIT_CYCLES-1, next state STALL if WAIT_CYCLES>1, else GRANT; no trigger stays IDLE.
- REQ-017: STALL: wait[i]=1; counter decrements each cycle; transition to GRANT on the cycle counter==1, giving exactly WAIT_CYCLES consecutive wait cycles including the IDLE trigger cycle.
- REQ-018: GRANT: wait[i]=0 for exactly one cycle regardless of req, addr, mode; next state IDLE; access completes in this cycle.
- REQ-019: A new trigger is evaluated only in IDLE; back-to-back triggered accesses therefore show WAIT_CYCLES wait, 1 grant, repeat.
- REQ-020: req, addr or mode changing during STALL/GRANT has no effect on the current sequence.
- REQ-021: With WAIT_CYCLES=2, sequence matches prior behaviour: wait 1,1,0 then IDLE.
- REQ-022: LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle, shared by all ports; port i samples bit i.
- REQ-023: stall_cnt[i] increments by 1 every cycle wait[i]=1, saturates at 16'hFFFF (no wrap).
- REQ-024: clr_cnt clears all counters to 0 on the next edge; clear wins over simultaneous increment.
- REQ-025: Ports fully independent; simultaneous triggers on all ports are legal and each runs its own sequence.

Reset
- REQ-026: reset low asynchronously forces all FSMs to IDLE, counters and stall_cnt to 0, LFSR to LFSR_SEED.
- REQ-027: wait forced to 0 while reset is low, regardless of req.
- REQ-028: Reset asserted mid-STALL aborts the sequence; after release, port starts in IDLE and the next access is evaluated fresh.
- REQ-029: Reset deassertion is synchronised by the integrator; the block takes first state change on the first rising edge with reset high.

Verification
- REQ-030: Defaults, port0 mode 01, req=1, addr=32'h0000_100C held -> wait0 = 1,1,0,1,1,0...; addr=32'h0000_1008 -> wait0=0 constantly.
- REQ-031: WAIT_CYCLES=5, mode 10, single-cycle req pulse -> wait 1 for 5 cycles, then 0; stall_cnt=5.
- REQ-032: Port0 mode 10, port1 mode 00, both req=1 -> wait0 pattern 1,1,0 repeating; wait1=0; stall_cnt1 stays 0.
- REQ-033: Reset low during 2nd STALL cycle of WAIT_CYCLES=4 -> wait 0 immediately; stall_cnt=0; after release, req with trigger -> wait 1 same cycle.
- REQ-034: Preload stall_cnt to 16'hFFFE via continuous stall, then 3 more stall cycles -> holds 16'hFFFF; clr_cnt coincident with stall -> 0 next cycle.
- REQ-035: Mode 11, req=1 continuous, 1000 cycles -> wait pattern matches reference LFSR model from 16'hACE1 exactly.
